// File: rtl/iob_integ_decim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iob_integ_decim_pkg                                             |
// | Purpose  : Shared widths and the last-count helper for the CIC integrator  |
// |            / decimator and its matching first-difference stage.            |
// | Contents : DEF_DATA_W, DEF_ACC_W, DEF_DECIM_W default widths;              |
// |            last_count() maps a ratio register to the final count value.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package iob_integ_decim_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ACC_W   = 32;
  localparam int unsigned DEF_DECIM_W = 8;

  // A ratio of 0 behaves like a ratio of 1, so both map to a last count of 0.
  function automatic logic [31:0] last_count(input logic [31:0] ratio);
    return (ratio == 32'd0) ? 32'd0 : ratio - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_modcnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iob_modcnt                                                      |
// | Purpose  : Modulo-(last_i+1) counter with increment, clear and wrap flag.  |
// | Ports    : clk_i, rst_n_i (sync, active-low), cke_i (freeze when 0),       |
// |            clr_i (sync clear), inc_i (advance), last_i (terminal count),   |
// |            wrap_o (count currently equals last_i).                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module iob_modcnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         cke_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic         wrap_o
);

  logic [W-1:0] r_cnt;

  assign wrap_o = (r_cnt == last_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        r_cnt <= '0;
      end else if (inc_i) begin
        r_cnt <= wrap_o ? '0 : r_cnt + W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_integ_decim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iob_integ_decim                                                 |
// | Purpose  : Integrator + decimate-by-R front half of a CIC decimator.       |
// |            Accumulates signed samples modulo 2^ACC_W and emits one         |
// |            accumulator snapshot every R accepted samples.                  |
// | Ports    : clk_i, rst_n_i (sync, active-low), cke_i (global freeze),       |
// |            en_i (run; 0 stalls input and reloads ratio), ratio_i (R),      |
// |            in_valid_i/in_ready_o/data_i (sample input),                    |
// |            out_valid_o/out_ready_i/data_o (decimated output).              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module iob_integ_decim
  import iob_integ_decim_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned DECIM_W = DEF_DECIM_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cke_i,
  input  logic               en_i,
  input  logic [DECIM_W-1:0] ratio_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   data_o
);

  logic [DECIM_W-1:0] r_ratio_q;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_data;
  logic               r_valid;

  logic [DECIM_W-1:0] w_last;
  logic               w_wrap;
  logic               w_in_ready;
  logic               w_accept;
  logic [ACC_W-1:0]   w_sext;
  logic [ACC_W-1:0]   w_sum;

  assign w_last = DECIM_W'(last_count(32'(r_ratio_q)));

  if (ACC_W > DATA_W) begin : g_sext
    assign w_sext = {{(ACC_W-DATA_W){data_i[DATA_W-1]}}, data_i};
  end else begin : g_nosext
    assign w_sext = data_i[ACC_W-1:0];
  end

  // Modulo add: wrap is intentional, the downstream differencer cancels it.
  assign w_sum = r_acc + w_sext;

  // Only the group-completing sample needs a free output slot; earlier
  // samples of the next group may flow while the output is stalled.
  assign w_in_ready = rst_n_i & cke_i & en_i & (~r_valid | out_ready_i | ~w_wrap);
  assign w_accept   = in_valid_i & w_in_ready;

  iob_modcnt #(
    .W (DECIM_W)
  ) u_modcnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .cke_i   (cke_i),
    .clr_i   (~en_i),
    .inc_i   (w_accept),
    .last_i  (w_last),
    .wrap_o  (w_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ratio_q <= '0;
      r_acc     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else if (cke_i) begin
      if (!en_i) begin
        r_ratio_q <= ratio_i;
      end
      if (w_accept) begin
        r_acc <= w_sum;
      end
      // A new load in the same cycle as a consume keeps valid high.
      if (w_accept && w_wrap) begin
        r_data  <= w_sum;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_valid;
  assign data_o      = r_data;

endmodule
`default_nettype wire
